// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Iterative multiply/divide unit owning the HI/LO pair.
//                Handles MULT, MULTU, DIV, DIVU via a WIDTH-step shift-add /
//                restoring shift-subtract loop, and MTHI/MTLO writes.
//                Optional macro MDU_DIV0_FLAG_EN: divide by zero skips the
//                loop, leaves HI/LO untouched and raises div0 with done.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_neg_lo;     // negate product / quotient at FIX
    logic               r_neg_hi;     // negate remainder at FIX
    logic [WIDTH-1:0]   r_acc;        // upper accumulator / partial remainder
    logic [WIDTH-1:0]   r_q;          // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0]   r_opnd;       // multiplicand / divisor magnitude
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    // Operand magnitudes: signed ops (op[0]=0) work on |a| and |b|
    logic               w_signed;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    assign w_signed = ~op[0];
    assign w_abs_a  = (w_signed && a[WIDTH-1]) ? -a : a;
    assign w_abs_b  = (w_signed && b[WIDTH-1]) ? -b : b;

    // One multiply step: conditional add with carry, then shift right
    logic [WIDTH:0]     w_sum;
    assign w_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

    // One divide step: shift {rem,quot} left, trial-subtract divisor.
    // The remainder stays below the divisor, so WIDTH+1 bits hold the trial.
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    assign w_rem_sh = {r_acc, r_q[WIDTH-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_opnd};

    // Sign correction applied when results are committed
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = r_neg_lo ? -w_prod : w_prod;
    assign w_quot_fix = r_neg_lo ? -r_q : r_q;
    assign w_rem_fix  = r_neg_hi ? -r_acc : r_acc;

`ifdef MDU_DIV0_FLAG_EN
    logic w_div_by_zero;
    logic r_dz;
    logic r_div0;
    assign w_div_by_zero = op[1] && (b == '0);
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: IDLE -> RUN (WIDTH steps) -> FIX -> IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
`ifdef MDU_DIV0_FLAG_EN
                    w_next = w_div_by_zero ? S_FIX : S_RUN;
`else
                    w_next = S_RUN;
`endif
                end
            end
            S_RUN: begin
                if (r_cnt == CW'(1)) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, HI/LO commit and MTHI/MTLO writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_acc    <= '0;
            r_q      <= '0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
            r_dz     <= 1'b0;
            r_div0   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
            r_div0 <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start) begin
                        r_is_div <= op[1];
                        r_acc    <= '0;
                        r_cnt    <= CW'(WIDTH);
                        r_neg_lo <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_hi <= w_signed & op[1] & a[WIDTH-1];
                        if (op[1]) begin
                            r_q    <= w_abs_a;
                            r_opnd <= w_abs_b;
                        end else begin
                            r_q    <= w_abs_b;
                            r_opnd <= w_abs_a;
                        end
`ifdef MDU_DIV0_FLAG_EN
                        r_dz <= w_div_by_zero;
`endif
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_is_div) begin
                        r_acc <= w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
                    end else begin
                        r_acc <= w_sum[WIDTH:1];
                        r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    r_done <= 1'b1;
`ifdef MDU_DIV0_FLAG_EN
                    if (r_dz) begin
                        r_div0 <= 1'b1;
                    end else
`endif
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quot_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
`ifdef MDU_DIV0_FLAG_EN
    assign div0 = r_div0;
`else
    assign div0 = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_div_unit
//  Description : Self-checking bench for mul_div_unit: vector table with a
//                result scoreboard, plus sequences for MTHI/MTLO, ignored
//                start/writes while busy, divide by zero and mid-op reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .div0  (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Launch one operation and check the result popped from the scoreboard.
    // mode 0: plain; 1: second start + MTHI mid-RUN; 2: MTHI on the start edge
    task automatic run_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] eh, input logic [31:0] el, input int lat,
                          input logic ed0, input int mode, input string nm);
        exp_t        e;
        int          cycles;
        int          busy_n;
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;
        e.hi = eh; e.lo = el; e.div0 = ed0;
        sb.push_back(e);
        op = o; a = va; b = vb; start = 1'b1;
        if (mode == 2) begin
            hi_we = 1'b1;
            wdata = 32'h0000_0055;
        end
        tick();
        start = 1'b0;
        hi_we = 1'b0;
        if (mode == 2) chk({nm, "_mthi_same_edge"}, hi, 32'h0000_0055);
        hold_hi = hi;
        hold_lo = lo;
        cycles  = 0;
        busy_n  = 0;
        while (!done && cycles < 200) begin
            if (busy) busy_n++;
            if (mode == 1 && cycles == 5) begin
                start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
                hi_we = 1'b1; wdata = 32'h0000_DEAD;
            end else begin
                start = 1'b0;
                hi_we = 1'b0;
            end
            tick();
            cycles++;
            if (mode == 1 && cycles == 10) begin
                chk({nm, "_hi_hold"}, hi, hold_hi);
                chk({nm, "_lo_hold"}, lo, hold_lo);
            end
        end
        chk({nm, "_latency"}, 32'(cycles), 32'(lat));
        chk({nm, "_busy_cycles"}, 32'(busy_n), 32'(lat));
        chk({nm, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({nm, "_hi"}, hi, e.hi);
            chk({nm, "_lo"}, lo, e.lo);
            chk({nm, "_div0"}, {31'd0, div0}, {31'd0, e.div0});
        end
        tick();
        chk({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    // Single-cycle MTHI/MTLO write while idle
    task automatic mt_write(input logic whi, input logic [31:0] d);
        hi_we = whi;
        lo_we = ~whi;
        wdata = d;
        tick();
        hi_we = 1'b0;
        lo_we = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen_done;

        vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[3] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[6] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[7] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
        vecs[9] = '{2'b10, 32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2};

        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_div0", {31'd0, div0}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset = 1'b0;
        tick();

        // MTLO / MTHI while idle
        mt_write(1'b0, 32'h0000_1234);
        chk("mtlo", lo, 32'h0000_1234);
        mt_write(1'b1, 32'h0000_ABCD);
        chk("mthi", hi, 32'h0000_ABCD);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                   33, 1'b0, 0, $sformatf("v%0d", i));
        end

        // Start and MTHI issued mid-RUN are ignored
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0, 1, "busy_ignore");
        // MTHI on the start edge lands, then the result overwrites it
        run_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 33, 1'b0, 2, "mt_and_start");

        // Divide by zero
        mt_write(1'b1, 32'h0000_AAAA);
        mt_write(1'b0, 32'h0000_BBBB);
`ifdef MDU_DIV0_FLAG_EN
        run_op(2'b11, 32'd5, 32'd0, 32'h0000_AAAA, 32'h0000_BBBB, 1, 1'b1, 0, "divu_by0");
        run_op(2'b10, 32'h8000_0000, 32'd0, 32'h0000_AAAA, 32'h0000_BBBB, 1, 1'b1, 0, "div_by0");
`else
        run_op(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 33, 1'b0, 0, "divu_by0");
        run_op(2'b10, 32'h8000_0000, 32'd0, 32'h8000_0000, 32'h0000_0001, 33, 1'b0, 0, "div_by0");
        run_op(2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 33, 1'b0, 0, "div_pos_by0");
`endif

        // Reset around cycle 10 of a DIV aborts with no done pulse
        op = 2'b10; a = 32'hFFFF_FFF9; b = 32'd2; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        tick();
        reset = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        chk("abort_no_done", {31'd0, seen_done}, 32'd0);
        run_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 33, 1'b0, 0, "after_reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
